shift_pipe: RTL and testbench

SHIFT_PIPE -- requirements
Module: shift_pipe

---
 rtl/shift_pipe_pkg.sv | 12 +
 rtl/shift_pipe_stage.sv | 45 ++++
 rtl/shift_pipe.sv | 101 ++++++++++
 tb/tb_shift_pipe.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/shift_pipe_pkg.sv
// Shared constants and helpers for the shift_pipe block.
package shift_pipe_pkg;

  localparam int DEFAULT_WIDTH = 8;
  localparam int DEFAULT_DEPTH = 4;

  // Width of an occupancy counter that must represent 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth + 1);
  endfunction

endpackage

// File: rtl/shift_pipe_stage.sv
// One pipeline stage: a data word plus its valid flag, with prioritised selects.
module shift_pipe_stage #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             flush,
  input  logic             load,
  input  logic             shift_left,
  input  logic             shift_right,
  input  logic [WIDTH-1:0] load_data,
  input  logic [WIDTH-1:0] left_data,
  input  logic             left_valid,
  input  logic [WIDTH-1:0] right_data,
  input  logic             right_valid,
  output logic [WIDTH-1:0] data,
  output logic             valid
);

  logic [WIDTH-1:0] data_reg;
  logic             valid_reg;

  // Flush only drops the flag; the data word is kept for observation.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      data_reg  <= '0;
      valid_reg <= 1'b0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      valid_reg <= 1'b1;
    end else if (shift_left) begin
      data_reg  <= left_data;
      valid_reg <= left_valid;
    end else if (shift_right) begin
      data_reg  <= right_data;
      valid_reg <= right_valid;
    end
  end

  assign data  = data_reg;
  assign valid = valid_reg;

endmodule

// File: rtl/shift_pipe.sv
// Bidirectional shift pipeline with parallel load, flush and occupancy count.
// Define SHIFT_PIPE_TAPS_EN to expose every stage's data on the Taps output.
module shift_pipe
  import shift_pipe_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH,
  parameter int DEPTH = DEFAULT_DEPTH
) (
  input  logic                            Clock,
  input  logic                            Resetn,
  input  logic                            Flush,
  input  logic                            Load,
  input  logic                            En,
  input  logic                            Dir,
  input  logic [WIDTH-1:0]                D,
  input  logic [WIDTH*DEPTH-1:0]          P,
  output logic [WIDTH-1:0]                Q,
  output logic                            Valid,
  output logic [count_width(DEPTH)-1:0]   Count,
  output logic                            Full
`ifdef SHIFT_PIPE_TAPS_EN
  ,
  output logic [WIDTH*DEPTH-1:0]          Taps
`endif
);

  localparam int CW = count_width(DEPTH);

  logic [WIDTH-1:0] stage_data  [DEPTH];
  logic             stage_valid [DEPTH];
  logic             shift_left;
  logic             shift_right;
  logic [CW-1:0]    valid_count;

  assign shift_left  = En & ~Dir;
  assign shift_right = En & Dir;

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      logic [WIDTH-1:0] left_data;
      logic             left_valid;
      logic [WIDTH-1:0] right_data;
      logic             right_valid;

      // End stages take serial input D in place of the missing neighbour.
      if (gi == 0) begin : g_left_in
        assign left_data  = D;
        assign left_valid = 1'b1;
      end else begin : g_left_nb
        assign left_data  = stage_data[gi-1];
        assign left_valid = stage_valid[gi-1];
      end

      if (gi == DEPTH - 1) begin : g_right_in
        assign right_data  = D;
        assign right_valid = 1'b1;
      end else begin : g_right_nb
        assign right_data  = stage_data[gi+1];
        assign right_valid = stage_valid[gi+1];
      end

      shift_pipe_stage #(
        .WIDTH(WIDTH)
      ) u_stage (
        .clk        (Clock),
        .resetn     (Resetn),
        .flush      (Flush),
        .load       (Load),
        .shift_left (shift_left),
        .shift_right(shift_right),
        .load_data  (P[gi*WIDTH +: WIDTH]),
        .left_data  (left_data),
        .left_valid (left_valid),
        .right_data (right_data),
        .right_valid(right_valid),
        .data       (stage_data[gi]),
        .valid      (stage_valid[gi])
      );

`ifdef SHIFT_PIPE_TAPS_EN
      assign Taps[gi*WIDTH +: WIDTH] = stage_data[gi];
`endif
    end
  endgenerate

  // Output end follows Dir combinationally so a direction change is seen at once.
  assign Q     = Dir ? stage_data[0]  : stage_data[DEPTH-1];
  assign Valid = Dir ? stage_valid[0] : stage_valid[DEPTH-1];

  always_comb begin
    valid_count = '0;
    for (int i = 0; i < DEPTH; i++) begin
      valid_count = valid_count + CW'(stage_valid[i]);
    end
  end

  assign Count = valid_count;
  assign Full  = (valid_count == CW'(DEPTH));

endmodule

// File: tb/tb_shift_pipe.sv
// Self-checking bench for shift_pipe (DEPTH=4 and DEPTH=1 instances side by side).
module tb_shift_pipe;

  typedef struct {
    logic [7:0] data;
    bit         valid;
  } stage_t;
  typedef stage_t q_t[$];

  logic        clk = 1'b0;
  logic        resetn, flush, load, en, dir;
  logic [7:0]  d;
  logic [31:0] p;

  logic [7:0]  q4, q1;
  logic        valid4, valid1, full4, full1;
  logic [2:0]  count4;
  logic [0:0]  count1;
`ifdef SHIFT_PIPE_TAPS_EN
  logic [31:0] taps4;
  logic [7:0]  taps1;
`endif

  int checks = 0;
  int errors = 0;
  bit started = 0;
  q_t m4, m1;

  always #5 clk = ~clk;

  shift_pipe #(.WIDTH(8), .DEPTH(4)) u_dut4 (
    .Clock(clk), .Resetn(resetn), .Flush(flush), .Load(load), .En(en), .Dir(dir),
    .D(d), .P(p), .Q(q4), .Valid(valid4), .Count(count4), .Full(full4)
`ifdef SHIFT_PIPE_TAPS_EN
    , .Taps(taps4)
`endif
  );

  shift_pipe #(.WIDTH(8), .DEPTH(1)) u_dut1 (
    .Clock(clk), .Resetn(resetn), .Flush(flush), .Load(load), .En(en), .Dir(dir),
    .D(d), .P(p[7:0]), .Q(q1), .Valid(valid1), .Count(count1), .Full(full1)
`ifdef SHIFT_PIPE_TAPS_EN
    , .Taps(taps1)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  // Model: stage list indexed by stage number; shifting is insert-at-input-end, drop-at-output-end.
  function automatic q_t nxt(input q_t s, input int depth, input bit rn, input bit fl,
                             input bit ld, input bit sh, input bit dr,
                             input logic [7:0] dd, input logic [31:0] pp);
    q_t r = s;
    stage_t e;
    if (!rn) begin
      r = {};
      for (int i = 0; i < depth; i++) r.push_back('{8'h00, 1'b0});
    end else if (fl) begin
      foreach (r[i]) r[i].valid = 1'b0;
    end else if (ld) begin
      r = {};
      for (int i = 0; i < depth; i++) r.push_back('{pp[i*8 +: 8], 1'b1});
    end else if (sh) begin
      e = '{dd, 1'b1};
      if (!dr) begin
        r.push_front(e);
        void'(r.pop_back());
      end else begin
        r.push_back(e);
        void'(r.pop_front());
      end
    end
    return r;
  endfunction

  function automatic logic [7:0] m_q(input q_t s, input bit dr);
    return dr ? s[0].data : s[s.size()-1].data;
  endfunction

  function automatic bit m_valid(input q_t s, input bit dr);
    return dr ? s[0].valid : s[s.size()-1].valid;
  endfunction

  function automatic int m_count(input q_t s);
    int c = 0;
    foreach (s[i]) c += int'(s[i].valid);
    return c;
  endfunction

  function automatic logic [31:0] m_taps(input q_t s);
    logic [31:0] t = '0;
    foreach (s[i]) t[i*8 +: 8] = s[i].data;
    return t;
  endfunction

  always @(negedge clk) begin
    if (started) begin
      chk("q4",     32'(q4),     32'(m_q(m4, dir)));
      chk("valid4", 32'(valid4), 32'(m_valid(m4, dir)));
      chk("count4", 32'(count4), 32'(m_count(m4)));
      chk("full4",  32'(full4),  32'(m_count(m4) == 4));
      chk("q1",     32'(q1),     32'(m_q(m1, dir)));
      chk("valid1", 32'(valid1), 32'(m_valid(m1, dir)));
      chk("count1", 32'(count1), 32'(m_count(m1)));
      chk("full1",  32'(full1),  32'(m_count(m1) == 1));
`ifdef SHIFT_PIPE_TAPS_EN
      chk("taps4",  taps4,       m_taps(m4));
      chk("taps1",  32'(taps1),  32'(m_taps(m1)));
`endif
    end
  end

  task automatic step(input bit rn, input bit fl, input bit ld, input bit sh, input bit dr,
                      input logic [7:0] dd, input logic [31:0] pp);
    resetn = rn; flush = fl; load = ld; en = sh; dir = dr; d = dd; p = pp;
    @(posedge clk);
    m4 = nxt(m4, 4, rn, fl, ld, sh, dr, dd, pp);
    m1 = nxt(m1, 1, rn, fl, ld, sh, dr, dd, pp);
    started = 1;
    @(negedge clk);
    #2;
    $display("step rn=%0b fl=%0b ld=%0b en=%0b dir=%0b d=%02h p=%08h -> q4=%02h v4=%0b c4=%0d q1=%02h",
             rn, fl, ld, sh, dr, dd, pp, q4, valid4, count4, q1);
  endtask

  initial begin
    resetn = 0; flush = 0; load = 0; en = 0; dir = 0; d = '0; p = '0;

    step(0, 0, 0, 0, 0, 8'h00, 32'h0);
    chk("rst_q", 32'(q4), 32'h0);
    chk("rst_valid", 32'(valid4), 32'h0);
    chk("rst_count", 32'(count4), 32'h0);
    chk("rst_full", 32'(full4), 32'h0);

    step(1, 0, 0, 1, 0, 8'h11, 32'h0);
    step(1, 0, 0, 1, 0, 8'h22, 32'h0);
    step(1, 0, 0, 1, 0, 8'h33, 32'h0);
    step(1, 0, 0, 1, 0, 8'h44, 32'h0);
    chk("fill_q", 32'(q4), 32'h11);
    chk("fill_valid", 32'(valid4), 32'h1);
    chk("fill_count", 32'(count4), 32'h4);
    chk("fill_full", 32'(full4), 32'h1);
    step(1, 0, 0, 1, 0, 8'h55, 32'h0);
    chk("sat_q", 32'(q4), 32'h22);
    chk("sat_count", 32'(count4), 32'h4);

    step(1, 0, 1, 1, 0, 8'h99, 32'h44332211);
    chk("load_q", 32'(q4), 32'h44);
    chk("load_count", 32'(count4), 32'h4);
    chk("load_q1", 32'(q1), 32'h11);
    dir = 1;
    #1;
    chk("dir_q", 32'(q4), 32'h11);
    chk("dir_valid", 32'(valid4), 32'h1);

    step(1, 1, 0, 0, 0, 8'h00, 32'h0);
    chk("flush_count", 32'(count4), 32'h0);
    chk("flush_hold_q", 32'(q4), 32'h44);
    step(1, 0, 0, 1, 0, 8'hA1, 32'h0);
    step(1, 0, 0, 1, 0, 8'hA2, 32'h0);
    chk("two_count", 32'(count4), 32'h2);
    step(1, 1, 1, 1, 0, 8'hEE, 32'hFFFFFFFF);
    chk("fl_ld_count", 32'(count4), 32'h0);
    chk("fl_ld_valid", 32'(valid4), 32'h0);
`ifdef SHIFT_PIPE_TAPS_EN
    chk("fl_ld_taps", taps4, 32'h2211A1A2);
`endif

    step(1, 0, 0, 1, 0, 8'hC1, 32'h0);
    step(1, 0, 0, 1, 0, 8'hC2, 32'h0);
    step(1, 0, 0, 1, 1, 8'hC3, 32'h0);
    chk("rev_count", 32'(count4), 32'h2);
    chk("rev_q", 32'(q4), 32'hC1);
    chk("rev_valid", 32'(valid4), 32'h1);

    step(1, 0, 1, 0, 0, 8'h00, 32'hDEADBEEF);
    chk("full_again", 32'(full4), 32'h1);
    step(0, 0, 0, 1, 0, 8'h77, 32'h0);
    chk("mid_rst_q", 32'(q4), 32'h0);
    chk("mid_rst_count", 32'(count4), 32'h0);
    chk("mid_rst_full", 32'(full4), 32'h0);
    step(1, 0, 0, 1, 0, 8'h5A, 32'h0);
    chk("post_rst_count", 32'(count4), 32'h1);

    step(1, 0, 0, 1, 0, 8'hA5, 32'h0);
    chk("d1_q", 32'(q1), 32'hA5);
    chk("d1_valid", 32'(valid1), 32'h1);
    chk("d1_full", 32'(full1), 32'h1);
    for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 0, 8'h3C, 32'h0);
    chk("d1_hold_q", 32'(q1), 32'hA5);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
